// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with a pedestrian walk lamp.
// Runs a demand-actuated day cycle and a flashing night mode.
module traffic_phase_controller #(
  parameter int unsigned MAIN_GREEN_S = 20,
  parameter int unsigned SIDE_GREEN_S = 10,
  parameter int unsigned YELLOW_S     = 3,
  parameter int unsigned ALL_RED_S    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       day_mode,
  input  logic       side_request,
  input  logic       ped_request,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  typedef enum logic [2:0] {
    ALL_RED_B,
    MAIN_GREEN,
    MAIN_YELLOW,
    ALL_RED_A,
    SIDE_GREEN,
    SIDE_YELLOW,
    NIGHT_FLASH
  } state_t;

  localparam logic [7:0] LP_MG_MIN  = 8'(MAIN_GREEN_S);
  localparam logic [7:0] LP_SG_LAST = 8'(SIDE_GREEN_S - 1);
  localparam logic [7:0] LP_Y_LAST  = 8'(YELLOW_S - 1);
  localparam logic [7:0] LP_AR_LAST = 8'(ALL_RED_S - 1);

  localparam logic [2:0] LP_RED = 3'b100;
  localparam logic [2:0] LP_YEL = 3'b010;
  localparam logic [2:0] LP_GRN = 3'b001;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tmr;
  logic       r_req;
  logic       r_fl;
  logic       w_entry;
  logic       w_min_done;

  assign w_entry    = (w_next != r_state);
  assign w_min_done = (r_tmr >= LP_MG_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ALL_RED_B;
      r_tmr   <= '0;
      r_req   <= 1'b0;
      r_fl    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_entry) begin
        r_tmr <= '0;
      end else if (sec_tick && (r_tmr != '1)) begin
        r_tmr <= r_tmr + 8'd1;
      end

      // Entering side green serves the request; a request seen in that same cycle is absorbed.
      if (w_entry && (w_next == SIDE_GREEN)) begin
        r_req <= 1'b0;
      end else if (side_request || ped_request) begin
        r_req <= 1'b1;
      end

      if (w_entry && (w_next == NIGHT_FLASH)) begin
        r_fl <= 1'b0;
      end else if ((r_state == NIGHT_FLASH) && sec_tick) begin
        r_fl <= ~r_fl;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    main_light = LP_RED;
    side_light = LP_RED;
    walk       = 1'b0;
    case (r_state)
      ALL_RED_B: begin
        if (sec_tick && (r_tmr == LP_AR_LAST)) w_next = MAIN_GREEN;
      end
      MAIN_GREEN: begin
        main_light = LP_GRN;
        // A pending request wins over the night fallback.
        if (w_min_done) begin
          if (r_req)          w_next = MAIN_YELLOW;
          else if (!day_mode) w_next = NIGHT_FLASH;
        end
      end
      MAIN_YELLOW: begin
        main_light = LP_YEL;
        if (sec_tick && (r_tmr == LP_Y_LAST)) w_next = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (sec_tick && (r_tmr == LP_AR_LAST)) w_next = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        side_light = LP_GRN;
        walk       = 1'b1;
        if (sec_tick && (r_tmr == LP_SG_LAST)) w_next = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        side_light = LP_YEL;
        if (sec_tick && (r_tmr == LP_Y_LAST)) w_next = ALL_RED_B;
      end
      NIGHT_FLASH: begin
        main_light = {1'b0, r_fl, 1'b0};
        side_light = {r_fl, 2'b00};
        if (sec_tick && day_mode) w_next = ALL_RED_B;
      end
      default: begin
        w_next = ALL_RED_B;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: expected light phases (lamps + length in ticks) are queued
// as stimulus is applied and matched against each completed output phase.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_tick;
  logic       day_mode;
  logic       side_request;
  logic       ped_request;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic [7:0] t;
  } seg_t;

  seg_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   tick_en = 1'b0;

  traffic_phase_controller #(
    .MAIN_GREEN_S(20),
    .SIDE_GREEN_S(10),
    .YELLOW_S    (3),
    .ALL_RED_S   (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sec_tick    (sec_tick),
    .day_mode    (day_mode),
    .side_request(side_request),
    .ped_request (ped_request),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [2:0] s, input logic w, input int t);
    seg_t e;
    e.m = m;
    e.s = s;
    e.w = w;
    e.t = 8'(t);
    exp_q.push_back(e);
  endtask

  // Yellow, clearance, side green/walk, side yellow, clearance back to main.
  task automatic push_side_cycle();
    push(YEL, RED, 1'b0, 3);
    push(RED, RED, 1'b0, 2);
    push(RED, GRN, 1'b1, 10);
    push(RED, YEL, 1'b0, 3);
    push(RED, RED, 1'b0, 2);
  endtask

  task automatic push_flash(input int n);
    for (int i = 0; i < n; i++) begin
      if ((i % 2) == 1) push(YEL, RED, 1'b0, 1);
      else              push(OFF, OFF, 1'b0, 1);
    end
  endtask

  task automatic wait_tick(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(posedge clk);
        k++;
      end while ((sec_tick !== 1'b1) && (k < 64));
      chk("tick_seen", 32'(sec_tick), 32'd1);
    end
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while ((exp_q.size() > n) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk("q_level", 32'(exp_q.size()), 32'(n));
  endtask

  // One-cycle tick every 4 clocks, driven just after the rising edge.
  initial begin
    int ph;
    ph       = 0;
    sec_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph       = (ph + 1) % 4;
      sec_tick = tick_en && (ph == 0);
    end
  end

  logic [6:0] mon_prev;
  int         mon_cnt;
  bit         mon_have = 1'b0;

  always @(negedge clk) begin
    seg_t e;
    if (!rst_n) begin
      mon_have = 1'b0;
    end else begin
      chk("safety", 32'(!((main_light[1:0] != 2'b00) && (side_light[1:0] != 2'b00))), 32'd1);
      chk("walk_ok", 32'(!walk || (side_light == GRN && main_light == RED)), 32'd1);
      if (!mon_have || ({main_light, side_light, walk} != mon_prev)) begin
        if (mon_have) begin
          chk("seg_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("seg_lights", 32'(mon_prev), 32'({e.m, e.s, e.w}));
            chk("seg_ticks", 32'(mon_cnt), 32'(e.t));
          end
        end
        mon_prev = {main_light, side_light, walk};
        mon_cnt  = 0;
        mon_have = 1'b1;
      end
      if (sec_tick) mon_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    day_mode     = 1'b1;
    side_request = 1'b0;
    ped_request  = 1'b0;
    tick_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_main", 32'(main_light), 32'(RED));
    chk("rst_side", 32'(side_light), 32'(RED));
    chk("rst_walk", 32'(walk), 32'd0);

    // Power-up clearance, then green held with no demand.
    push(RED, RED, 1'b0, 2);
    @(negedge clk);
    rst_n   = 1'b1;
    tick_en = 1'b1;
    wait_q(0);
    wait_tick(30);
    #1;
    chk("hold_main", 32'(main_light), 32'(GRN));
    chk("hold_walk", 32'(walk), 32'd0);

    // Late request: yellow two clocks after the request cycle.
    push(GRN, RED, 1'b0, 30);
    push_side_cycle();
    @(negedge clk);
    side_request = 1'b1;
    @(posedge clk);
    #1;
    side_request = 1'b0;
    chk("lat_1clk", 32'(main_light), 32'(GRN));
    @(posedge clk);
    #1;
    chk("lat_2clk", 32'(main_light), 32'(YEL));
    wait_q(0);

    // Early ped request: waits out the minimum green.
    wait_tick(5);
    push(GRN, RED, 1'b0, 20);
    push_side_cycle();
    @(negedge clk);
    ped_request = 1'b1;
    @(negedge clk);
    ped_request = 1'b0;
    wait_q(0);

    // Night with no demand; request latched during night is served after day returns.
    @(negedge clk);
    day_mode = 1'b0;
    push(GRN, RED, 1'b0, 20);
    push_flash(6);
    push(RED, RED, 1'b0, 2);
    push(GRN, RED, 1'b0, 20);
    push_side_cycle();
    wait_q(13);
    wait_tick(2);
    @(negedge clk);
    ped_request = 1'b1;
    @(negedge clk);
    ped_request = 1'b0;
    wait_tick(3);
    @(negedge clk);
    day_mode = 1'b1;
    wait_q(0);

    // Night pending with a request: side cycle first, then night after minimum green.
    @(negedge clk);
    day_mode = 1'b0;
    wait_tick(3);
    push(GRN, RED, 1'b0, 20);
    push_side_cycle();
    push(GRN, RED, 1'b0, 20);
    push_flash(4);
    push(RED, RED, 1'b0, 2);
    @(negedge clk);
    side_request = 1'b1;
    @(negedge clk);
    side_request = 1'b0;
    wait_q(5);
    wait_tick(3);
    @(negedge clk);
    day_mode = 1'b1;
    wait_q(0);

    // Level request, then reset in the middle of side green.
    wait_tick(1);
    push(GRN, RED, 1'b0, 20);
    push(YEL, RED, 1'b0, 3);
    push(RED, RED, 1'b0, 2);
    @(negedge clk);
    side_request = 1'b1;
    repeat (3) @(negedge clk);
    side_request = 1'b0;
    wait_q(0);
    wait_tick(4);
    @(negedge clk);
    chk("sg_side", 32'(side_light), 32'(GRN));
    chk("sg_walk", 32'(walk), 32'd1);
    rst_n   = 1'b0;
    tick_en = 1'b0;
    #1;
    chk("arst_main", 32'(main_light), 32'(RED));
    chk("arst_side", 32'(side_light), 32'(RED));
    chk("arst_walk", 32'(walk), 32'd0);
    repeat (3) @(negedge clk);
    push(RED, RED, 1'b0, 2);
    rst_n   = 1'b1;
    tick_en = 1'b1;
    wait_q(0);
    wait_tick(25);
    #1;
    chk("final_main", 32'(main_light), 32'(GRN));
    chk("final_side", 32'(side_light), 32'(RED));
    chk("final_q", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
